// File: rtl/im2col_ch_sched.sv
// Per-channel launch scheduler for the im2col input unit.
// Walks channels 1..N through launch, ack, stream and drain, guarded by a watchdog.
module im2col_ch_sched #(
  parameter int CH_W      = 7,
  parameter int TMO_W     = 16,
  parameter int TMO_MAX   = 65535,
  parameter int DRAIN_CYC = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [CH_W-1:0] i_num_ch,
  input  logic            i_abort,
  input  logic            i_sa_ready,
  input  logic            i_unit_started,
  input  logic            i_unit_finished,
  output logic            o_inputs_start,
  output logic [CH_W-1:0] o_current_ch,
  output logic            o_busy,
  output logic            o_ch_done,
  output logic            o_done,
  output logic            o_err_tmo
);

  localparam int DRN  = (DRAIN_CYC < 1) ? 1 : DRAIN_CYC;
  localparam int DC_W = $clog2(DRN + 1);
  localparam logic [DC_W-1:0]  DRN_LAST = DC_W'(DRN - 1);
  localparam logic [TMO_W-1:0] WD_LAST  = TMO_W'(TMO_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WACK,
    S_STREAM,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state, w_state;
  logic [CH_W-1:0] r_num, w_num;
  logic [CH_W-1:0] r_ch, w_ch;
  logic [TMO_W-1:0] r_wd, w_wd;
  logic [DC_W-1:0] r_drn, w_drn;
  logic            r_is, w_is;
  logic            r_cd, w_cd;
  logic            r_dn, w_dn;
  logic            r_err, w_err;
  logic            r_busy, w_busy;

  always_comb begin
    w_state = r_state;
    w_num   = r_num;
    w_ch    = r_ch;
    w_wd    = r_wd;
    w_drn   = r_drn;
    w_is    = 1'b0;
    w_cd    = 1'b0;
    w_dn    = 1'b0;
    w_err   = r_err;
    if (i_abort && (r_state != S_IDLE)) begin
      w_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_num   = i_num_ch;
            w_ch    = CH_W'(1);
            w_err   = 1'b0;
            w_state = (i_num_ch != '0) ? S_LAUNCH : S_DONE;
          end
        end
        S_LAUNCH: begin
          if (i_sa_ready) begin
            w_is    = 1'b1;
            w_wd    = '0;
            w_state = S_WACK;
          end
        end
        // A finished level seen here belongs to the previous channel.
        S_WACK: begin
          if (i_unit_started) begin
            w_wd    = '0;
            w_state = S_STREAM;
          end else if (r_wd == WD_LAST) begin
            w_err   = 1'b1;
            w_state = S_ERR;
          end else begin
            w_wd = r_wd + TMO_W'(1);
          end
        end
        S_STREAM: begin
          if (i_unit_finished) begin
            w_cd    = 1'b1;
            w_drn   = '0;
            w_state = S_DRAIN;
          end else if (r_wd == WD_LAST) begin
            w_err   = 1'b1;
            w_state = S_ERR;
          end else begin
            w_wd = r_wd + TMO_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drn == DRN_LAST) begin
            if (r_ch == r_num) begin
              w_state = S_DONE;
            end else begin
              w_ch    = r_ch + CH_W'(1);
              w_state = S_LAUNCH;
            end
          end else begin
            w_drn = r_drn + DC_W'(1);
          end
        end
        S_DONE: begin
          w_dn    = 1'b1;
          w_state = S_IDLE;
        end
        S_ERR: begin
          w_state = S_IDLE;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_ch    <= '0;
      r_wd    <= '0;
      r_drn   <= '0;
      r_is    <= 1'b0;
      r_cd    <= 1'b0;
      r_dn    <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_num   <= w_num;
      r_ch    <= w_ch;
      r_wd    <= w_wd;
      r_drn   <= w_drn;
      r_is    <= w_is;
      r_cd    <= w_cd;
      r_dn    <= w_dn;
      r_err   <= w_err;
      r_busy  <= w_busy;
    end
  end

  assign o_inputs_start = r_is;
  assign o_current_ch   = r_ch;
  assign o_busy         = r_busy;
  assign o_ch_done      = r_cd;
  assign o_done         = r_dn;
  assign o_err_tmo      = r_err;

endmodule

// File: tb/tb_im2col_ch_sched.sv
// Directed bench for im2col_ch_sched: two instances (watchdog 16 and 8)
// share stimulus and are checked every cycle against an event-level model.
module tb_im2col_ch_sched;

  localparam int CW  = 7;
  localparam int DRN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst, i_start, i_abort, i_sa_ready;
  logic          i_unit_started, i_unit_finished;
  logic [CW-1:0] i_num_ch;
  logic          is_o [2];
  logic [CW-1:0] ch_o [2];
  logic          busy_o [2];
  logic          cd_o [2];
  logic          dn_o [2];
  logic          err_o [2];

  im2col_ch_sched #(.CH_W(CW), .TMO_W(16), .TMO_MAX(16), .DRAIN_CYC(DRN)) u0 (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_num_ch(i_num_ch),
    .i_abort(i_abort), .i_sa_ready(i_sa_ready),
    .i_unit_started(i_unit_started), .i_unit_finished(i_unit_finished),
    .o_inputs_start(is_o[0]), .o_current_ch(ch_o[0]), .o_busy(busy_o[0]),
    .o_ch_done(cd_o[0]), .o_done(dn_o[0]), .o_err_tmo(err_o[0]));

  im2col_ch_sched #(.CH_W(CW), .TMO_W(16), .TMO_MAX(8), .DRAIN_CYC(DRN)) u1 (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_num_ch(i_num_ch),
    .i_abort(i_abort), .i_sa_ready(i_sa_ready),
    .i_unit_started(i_unit_started), .i_unit_finished(i_unit_finished),
    .o_inputs_start(is_o[1]), .o_current_ch(ch_o[1]), .o_busy(busy_o[1]),
    .o_ch_done(cd_o[1]), .o_done(dn_o[1]), .o_err_tmo(err_o[1]));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: phase 0 idle,1 launch,2 wait ack,3 stream,4 drain,5 done,6 err
  int ph[2], ch[2], n[2], age[2], dr[2];
  bit e_is[2], e_cd[2], e_dn[2], e_err[2];
  int tmo[2] = '{16, 8};

  // Unit emulation and run-level tallies taken from DUT 0/1 outputs
  bit auto_u;
  int fin_dly, fin_cnt;
  int n_l0, n_cd0, n_dn0, n_dn1, l0_cyc, dn0_cyc, err0_cyc, err1_cyc;
  int l_ch[$];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_step(int k);
    e_is[k] = 0; e_cd[k] = 0; e_dn[k] = 0;
    if (i_rst) begin
      ph[k] = 0; ch[k] = 0; n[k] = 0; e_err[k] = 0; age[k] = 0; dr[k] = 0;
    end else if (i_abort && ph[k] != 0) begin
      ph[k] = 0;
    end else begin
      case (ph[k])
        0: if (i_start) begin
          n[k] = i_num_ch; ch[k] = 1; e_err[k] = 0;
          ph[k] = (i_num_ch != 0) ? 1 : 5;
        end
        1: if (i_sa_ready) begin e_is[k] = 1; ph[k] = 2; age[k] = 0; end
        2, 3: begin
          if (ph[k] == 2 && i_unit_started) begin
            ph[k] = 3; age[k] = 0;
          end else if (ph[k] == 3 && i_unit_finished) begin
            e_cd[k] = 1; ph[k] = 4; dr[k] = 0;
          end else begin
            age[k]++;
            if (age[k] == tmo[k]) begin ph[k] = 6; e_err[k] = 1; end
          end
        end
        4: begin
          dr[k]++;
          if (dr[k] == DRN) begin
            if (ch[k] == n[k]) ph[k] = 5;
            else begin ch[k]++; ph[k] = 1; end
          end
        end
        5: begin e_dn[k] = 1; ph[k] = 0; end
        default: ph[k] = 0;
      endcase
    end
  endtask

  task automatic tick();
    logic [11:0] a, e;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      e = {e_is[k], CW'(ch[k]), ph[k] != 0, e_cd[k], e_dn[k], e_err[k]};
      a = {is_o[k], ch_o[k], busy_o[k], cd_o[k], dn_o[k], err_o[k]};
      chk($sformatf("dut%0d {start,ch,busy,chdone,done,err}", k), 32'(a), 32'(e));
    end
    if (is_o[0]) begin
      n_l0++; l_ch.push_back(int'(ch_o[0]));
      if (l0_cyc < 0) l0_cyc = cyc;
    end
    if (cd_o[0]) n_cd0++;
    if (dn_o[0]) begin n_dn0++; dn0_cyc = cyc; end
    if (dn_o[1]) n_dn1++;
    if (err_o[0] && err0_cyc < 0) err0_cyc = cyc;
    if (err_o[1] && err1_cyc < 0) err1_cyc = cyc;
    if (auto_u) begin
      if (i_unit_started) begin
        i_unit_started = 0; i_unit_finished = 0; fin_cnt = fin_dly;
      end else if (e_is[0]) begin
        i_unit_started = 1;
      end else if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) i_unit_finished = 1;
      end
    end
  endtask

  task automatic clr();
    n_l0 = 0; n_cd0 = 0; n_dn0 = 0; n_dn1 = 0;
    l0_cyc = -1; dn0_cyc = -1; err0_cyc = -1; err1_cyc = -1;
    l_ch.delete();
  endtask

  task automatic do_reset();
    auto_u = 0; fin_cnt = 0;
    i_start = 0; i_abort = 0; i_unit_started = 0; i_unit_finished = 0;
    i_sa_ready = 1; i_num_ch = '0;
    i_rst = 1; tick(); tick();
    i_rst = 0;
    clr();
  endtask

  // Returns the cycle in which start was held high.
  task automatic go(int num, output int s);
    s = cyc;
    i_num_ch = CW'(num); i_start = 1; tick(); i_start = 0;
  endtask

  // which: 0 launches, 1 channel completions, 2 layer completions
  task automatic wait_cnt(string nm, int which, int target, int lim);
    int v;
    for (int i = 0; i < lim; i++) begin
      v = (which == 0) ? n_l0 : (which == 1) ? n_cd0 : n_dn0;
      if (v >= target) return;
      tick();
    end
    v = (which == 0) ? n_l0 : (which == 1) ? n_cd0 : n_dn0;
    chk({nm, " wait bound"}, 32'(v >= target), 32'd1);
  endtask

  int s;

  initial begin
    i_rst = 1; i_start = 0; i_abort = 0; i_sa_ready = 1;
    i_unit_started = 0; i_unit_finished = 0; i_num_ch = '0;
    auto_u = 0; fin_dly = 10; fin_cnt = 0;
    do_reset();
    chk("reset ch", 32'(ch_o[0]), 0);
    chk("reset busy", 32'(busy_o[0]), 0);

    // Three channels, ack one cycle after launch, finish ten cycles later
    auto_u = 1; fin_dly = 10;
    go(3, s);
    wait_cnt("3ch first launch", 0, 1, 20);
    i_num_ch = CW'(5); i_start = 1; tick(); i_start = 0;
    wait_cnt("3ch done", 2, 1, 200);
    tick(); tick();
    chk("3ch start->launch latency", 32'(l0_cyc - s), 2);
    chk("3ch launches", 32'(n_l0), 3);
    chk("3ch launch ch1", 32'(l_ch[0]), 1);
    chk("3ch launch ch2", 32'(l_ch[1]), 2);
    chk("3ch launch ch3", 32'(l_ch[2]), 3);
    chk("3ch ch_done pulses", 32'(n_cd0), 3);
    chk("3ch done pulses", 32'(n_dn0), 1);
    chk("3ch ch held in idle", 32'(ch_o[0]), 3);

    // Zero channels
    do_reset();
    go(0, s);
    for (int i = 0; i < 5; i++) tick();
    chk("zero done latency", 32'(dn0_cyc - s), 2);
    chk("zero launches", 32'(n_l0), 0);
    chk("zero done pulses", 32'(n_dn0), 1);

    // Array not ready for five cycles in launch
    do_reset();
    auto_u = 1; fin_dly = 10; i_sa_ready = 0;
    go(1, s);
    for (int i = 0; i < 5; i++) tick();
    chk("stall no launch", 32'(n_l0), 0);
    i_sa_ready = 1; tick();
    chk("stall single launch", 32'(n_l0), 1);
    wait_cnt("stall done", 2, 1, 60);
    chk("stall launch count", 32'(n_l0), 1);

    // Unit never acknowledges: watchdogs of 8 and 16
    do_reset();
    go(1, s);
    for (int i = 0; i < 24; i++) tick();
    chk("tmo8 err after 8 in wait", 32'(err1_cyc - l0_cyc), 8);
    chk("tmo16 err after 16 in wait", 32'(err0_cyc - l0_cyc), 16);
    chk("tmo8 busy after err", 32'(busy_o[1]), 0);
    chk("tmo8 sticky err", 32'(err_o[1]), 1);
    chk("tmo no done", 32'(n_dn0 + n_dn1), 0);
    go(1, s);
    chk("tmo err cleared by start", 32'(err_o[0]), 0);

    // Abort while streaming channel 2 of 4, then restart
    do_reset();
    auto_u = 1; fin_dly = 10;
    go(4, s);
    wait_cnt("abort reach ch2", 0, 2, 100);
    for (int i = 0; i < 4; i++) tick();
    i_abort = 1; tick(); i_abort = 0;
    chk("abort busy", 32'(busy_o[0]), 0);
    for (int i = 0; i < 30; i++) tick();
    chk("abort no more launches", 32'(n_l0), 2);
    chk("abort ch_done only ch1", 32'(n_cd0), 1);
    chk("abort no done", 32'(n_dn0), 0);
    auto_u = 0; i_unit_started = 0; i_unit_finished = 0; fin_cnt = 0;
    clr();
    go(4, s);
    wait_cnt("restart launch", 0, 1, 20);
    chk("restart at ch1", 32'(l_ch[0]), 1);

    // Reset during drain with finished still high afterwards
    do_reset();
    auto_u = 1; fin_dly = 3;
    go(2, s);
    wait_cnt("rst reach drain", 1, 1, 60);
    auto_u = 0; i_rst = 1; tick(); i_rst = 0;
    chk("rst outputs", 32'({is_o[0], ch_o[0], busy_o[0], cd_o[0], dn_o[0], err_o[0]}), 0);
    chk("rst stale finished held", 32'(i_unit_finished), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("rst no ch_done", 32'(n_cd0), 1);

    // Full-range channel count
    do_reset();
    auto_u = 1; fin_dly = 2;
    go(127, s);
    wait_cnt("max done", 2, 1, 4000);
    chk("max launches", 32'(n_l0), 127);
    chk("max ch_done", 32'(n_cd0), 127);
    chk("max last ch", 32'(ch_o[0]), 127);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
